// File: rtl/instqueue_pkg.sv
// Shared widths and small helpers for the fetch-to-decoder instruction queue.
// The instruction and address widths mirror the project-wide 32-bit defaults.
package instqueue_pkg;

    localparam int ID_WIDTH      = 32;
    localparam int ADDRESS_WIDTH = 32;
    localparam int ENTRY_WIDTH   = ID_WIDTH + ADDRESS_WIDTH;

    // Entries are stored as {inst, pc}, so the instruction occupies the upper half.
    function automatic logic [ID_WIDTH-1:0] entry_inst(input logic [ENTRY_WIDTH-1:0] entry);
        return entry[ENTRY_WIDTH-1:ADDRESS_WIDTH];
    endfunction

    function automatic logic [ADDRESS_WIDTH-1:0] entry_pc(input logic [ENTRY_WIDTH-1:0] entry);
        return entry[ADDRESS_WIDTH-1:0];
    endfunction

    function automatic logic [ENTRY_WIDTH-1:0] make_entry(
        input logic [ID_WIDTH-1:0]      inst,
        input logic [ADDRESS_WIDTH-1:0] pc
    );
        return {inst, pc};
    endfunction

endpackage

// File: rtl/instqueue_storage.sv
// Entry storage for the instruction queue: one synchronous write port and one
// asynchronous read port. Contents are deliberately left unreset.
module instqueue_storage
    import instqueue_pkg::*;
#(
    parameter int ADDR_BITS = 4
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [ADDR_BITS-1:0]   wr_addr,
    input  logic [ENTRY_WIDTH-1:0] wr_data,
    input  logic [ADDR_BITS-1:0]   rd_addr,
    output logic [ENTRY_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [ENTRY_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instqueue.sv
// Circular FIFO between instruction fetch and the decoder, with ROB and JAL
// redirect flushes, fetch back-pressure and dispatcher stall handling.
module instqueue
    import instqueue_pkg::*;
#(
    parameter int QUEUE_DEPTH_LOG = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     rdy_in,
    input  logic                     if_instqueue_en_in,
    input  logic [ID_WIDTH-1:0]      if_instqueue_inst_in,
    input  logic [ADDRESS_WIDTH-1:0] if_instqueue_pc_in,
    output logic                     instqueue_if_full_out,
    input  logic                     dispatcher_instqueue_stall_in,
    output logic                     instqueue_decoder_en_out,
    output logic [ID_WIDTH-1:0]      instqueue_decoder_inst_out,
    output logic [ADDRESS_WIDTH-1:0] instqueue_decoder_pc_out,
    input  logic                     decoder_instqueue_rst_in,
    input  logic                     rob_instqueue_rst_in
);

    localparam logic [QUEUE_DEPTH_LOG:0] FULL_COUNT = {1'b1, {QUEUE_DEPTH_LOG{1'b0}}};
    localparam logic [QUEUE_DEPTH_LOG:0] ONE_COUNT  = {{QUEUE_DEPTH_LOG{1'b0}}, 1'b1};
    localparam logic [QUEUE_DEPTH_LOG-1:0] ONE_PTR  = {{(QUEUE_DEPTH_LOG-1){1'b0}}, 1'b1};

    logic [QUEUE_DEPTH_LOG-1:0] head;
    logic [QUEUE_DEPTH_LOG-1:0] tail;
    logic [QUEUE_DEPTH_LOG:0]   count;

    logic                   empty;
    logic                   full;
    logic                   push;
    logic                   pop;
    logic                   flush;
    logic                   write_en;
    logic [ENTRY_WIDTH-1:0] head_entry;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // A pop is the decoder/dispatcher handshake, so it is also the decoder enable.
    assign pop   = rdy_in & ~empty & ~dispatcher_instqueue_stall_in & ~rob_instqueue_rst_in;
    assign push  = rdy_in & if_instqueue_en_in & ~full;
    assign flush = rob_instqueue_rst_in | decoder_instqueue_rst_in;

    // A push coinciding with a flush belongs to the stale fetch stream.
    assign write_en = push & ~flush;

    instqueue_storage #(
        .ADDR_BITS (QUEUE_DEPTH_LOG)
    ) u_storage (
        .clk     (clk_in),
        .wr_en   (write_en),
        .wr_addr (tail),
        .wr_data (make_entry(if_instqueue_inst_in, if_instqueue_pc_in)),
        .rd_addr (head),
        .rd_data (head_entry)
    );

    assign instqueue_if_full_out      = full;
    assign instqueue_decoder_en_out   = pop;
    assign instqueue_decoder_inst_out = empty ? '0 : entry_inst(head_entry);
    assign instqueue_decoder_pc_out   = empty ? '0 : entry_pc(head_entry);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (rob_instqueue_rst_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else if (decoder_instqueue_rst_in) begin
                // The JAL itself was popped this cycle; everything behind it is wrong-path.
                head  <= tail;
                count <= '0;
            end else begin
                if (push) begin
                    tail <= tail + ONE_PTR;
                end
                if (pop) begin
                    head <= head + ONE_PTR;
                end
                if (push && !pop) begin
                    count <= count + ONE_COUNT;
                end else if (pop && !push) begin
                    count <= count - ONE_COUNT;
                end
            end
        end
    end

    // A JAL redirect only makes sense in the cycle the JAL leaves the queue.
    assert property (@(posedge clk_in) disable iff (!rst_n_in)
        (rdy_in && decoder_instqueue_rst_in && !rob_instqueue_rst_in) |-> pop)
        else $error("decoder_instqueue_rst_in asserted without a pop");

endmodule
